diff_frame_rd: RTL

- Upstream feeder for the differencing stage. On a start pulse it reads one frame of READ_RAM_WIDTH-bit words from the sample RAM.
- Each word is sliced into NUM signed lanes of SAMPLE_WIDTH/2 bits and presented as a contiguous valid burst, with a last flag on the final word and the real/complex switch held stable for the whole frame.
- It owns RAM read addressing, read-latency alignment, frame length counting and the start/busy/done handshake with the stage controller.

---
 rtl/diff_frame_rd_if.sv | 36 +++
 rtl/diff_frame_rd.sv | 129 ++++++++++++
 2 files changed

// File: rtl/diff_frame_rd_if.sv
// Bus between the differencing-stage controller/sample RAM and the frame reader.
// master: controller and RAM side, slave: diff_frame_rd.
interface diff_frame_rd_if #(
  parameter int READ_RAM_WIDTH = 128,
  parameter int SAMPLE_WIDTH   = 32,
  parameter int NUM            = 8,
  parameter int ADDR_W         = 10,
  parameter int CNT_LEN        = 8
);
  logic                             i_start;
  logic                             i_clear;
  logic                             i_switch;
  logic [ADDR_W-1:0]                i_base_addr;
  logic [CNT_LEN-1:0]               i_len;
  logic                             o_busy;
  logic                             o_done;
  logic                             o_ram_rd_en;
  logic [ADDR_W-1:0]                o_ram_rd_addr;
  logic [READ_RAM_WIDTH-1:0]        i_ram_rd_data;
  logic signed [SAMPLE_WIDTH/2-1:0] o_x0_data [NUM];
  logic                             o_x0_valid;
  logic                             o_x0_last;
  logic                             o_switch;

  modport master (
    output i_start, i_clear, i_switch, i_base_addr, i_len, i_ram_rd_data,
    input  o_busy, o_done, o_ram_rd_en, o_ram_rd_addr, o_x0_data,
           o_x0_valid, o_x0_last, o_switch
  );

  modport slave (
    input  i_start, i_clear, i_switch, i_base_addr, i_len, i_ram_rd_data,
    output o_busy, o_done, o_ram_rd_en, o_ram_rd_addr, o_x0_data,
           o_x0_valid, o_x0_last, o_switch
  );
endinterface

// File: rtl/diff_frame_rd.sv
// Frame reader feeding the differencing stage: reads i_len RAM words from
// i_base_addr, realigns them to the RAM read latency and emits them as a
// gap-free burst of NUM signed lanes with a last flag on the final word.
//
// state | meaning
// IDLE  | waiting for an accepted start
// READ  | issuing one RAM read per cycle, address wraps modulo 2^ADDR_W
// DRAIN | reads issued, waiting for the latency tag pipeline to empty
// DONE  | one-cycle done pulse; starts are ignored here
module diff_frame_rd #(
  parameter int READ_RAM_WIDTH = 128,
  parameter int SAMPLE_WIDTH   = 32,
  parameter int NUM            = 8,
  parameter int ADDR_W         = 10,
  parameter int CNT_LEN        = 8,
  parameter int RD_LAT         = 2
) (
  input  logic          clk,
  input  logic          rst,
  diff_frame_rd_if.slave bus
);
  localparam int LW = SAMPLE_WIDTH / 2;

  if (READ_RAM_WIDTH != NUM * LW) begin : g_bad_width
    $error("READ_RAM_WIDTH must equal NUM*SAMPLE_WIDTH/2");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("RD_LAT must be in 1..4");
  end

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t             state;
  logic [CNT_LEN-1:0] len_q;
  logic [CNT_LEN-1:0] issue_cnt;
  logic [RD_LAT-1:0]  tag_v;
  logic [RD_LAT-1:0]  tag_l;
  logic               issue_last;

  // issue_cnt already counts the read on the bus, so equality marks the final word
  assign issue_last = bus.o_ram_rd_en && (issue_cnt == len_q);

  // Sequencer: start/abort handling, read addressing and frame counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      len_q             <= '0;
      issue_cnt         <= '0;
      bus.o_busy        <= 1'b0;
      bus.o_done        <= 1'b0;
      bus.o_ram_rd_en   <= 1'b0;
      bus.o_ram_rd_addr <= '0;
      bus.o_switch      <= 1'b0;
    end else if (bus.i_clear) begin
      state           <= IDLE;
      issue_cnt       <= '0;
      bus.o_busy      <= 1'b0;
      bus.o_done      <= 1'b0;
      bus.o_ram_rd_en <= 1'b0;
    end else begin
      bus.o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            if (bus.i_len != '0) begin
              len_q             <= bus.i_len;
              bus.o_switch      <= bus.i_switch;
              bus.o_ram_rd_addr <= bus.i_base_addr;
              bus.o_ram_rd_en   <= 1'b1;
              issue_cnt         <= CNT_LEN'(1);
              bus.o_busy        <= 1'b1;
              state             <= READ;
            end else begin
              bus.o_done <= 1'b1;
              state      <= DONE;
            end
          end
        end
        READ: begin
          if (issue_cnt == len_q) begin
            bus.o_ram_rd_en <= 1'b0;
            state           <= DRAIN;
          end else begin
            bus.o_ram_rd_addr <= bus.o_ram_rd_addr + ADDR_W'(1);
            issue_cnt         <= issue_cnt + CNT_LEN'(1);
          end
        end
        DRAIN: begin
          if (tag_v == '0) begin
            bus.o_busy <= 1'b0;
            bus.o_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Latency tags and output registers; lanes only update on a tagged word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v          <= '0;
      tag_l          <= '0;
      bus.o_x0_valid <= 1'b0;
      bus.o_x0_last  <= 1'b0;
      for (int n = 0; n < NUM; n++) bus.o_x0_data[n] <= '0;
    end else if (bus.i_clear) begin
      tag_v          <= '0;
      tag_l          <= '0;
      bus.o_x0_valid <= 1'b0;
      bus.o_x0_last  <= 1'b0;
    end else begin
      tag_v[0] <= bus.o_ram_rd_en;
      tag_l[0] <= issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_l[i] <= tag_l[i-1];
      end
      bus.o_x0_valid <= tag_v[RD_LAT-1];
      bus.o_x0_last  <= tag_l[RD_LAT-1];
      if (tag_v[RD_LAT-1]) begin
        for (int n = 0; n < NUM; n++)
          bus.o_x0_data[n] <= bus.i_ram_rd_data[n*LW +: LW];
      end
    end
  end
endmodule
